// File: rtl/montgomery_precompute_pkg.sv
// Shared constants and state encoding for the Montgomery precompute engine
// and the modular-exponentiation control that reuses them.
package montgomery_precompute_pkg;

  // Operand / modulus width.
  localparam int unsigned BITS  = 32;

  // Step counter width: covers the 2*BITS doubling steps.
  localparam int unsigned CNT_W = $clog2(2 * BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/montgomery_precompute_mod_double_step.sv
// One modular doubling step: r2_o = (2*r_i) mod n_i, assuming r_i < n_i.
// Because r_i < n_i, 2*r_i < 2*n_i, so a single conditional subtract suffices.
module mod_double_step
  import montgomery_precompute_pkg::*;
#(
  parameter int unsigned W = BITS
) (
  input  logic [W:0]   r_i,
  input  logic [W-1:0] n_i,
  output logic [W:0]   r2_o
);

  logic [W:0] t;

  // Double, then subtract the modulus once when the result reaches it.
  always_comb begin
    t    = r_i << 1;
    r2_o = (t >= {1'b0, n_i}) ? (t - {1'b0, n_i}) : t;
  end

endmodule

// File: rtl/montgomery_precompute.sv
// Computes N_prime = -N^-1 mod 2^BITS and R2 = 2^(2*BITS) mod N for an odd
// modulus N > 1, one bit/step per cycle over 2*BITS cycles, with a start/done
// handshake. Even N or N == 1 is rejected with error.
module montgomery_precompute
  import montgomery_precompute_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] N,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [BITS-1:0] N_prime,
  output logic [BITS-1:0] R2
);

  localparam logic [CNT_W-1:0] CNT_NP_END = CNT_W'(BITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * BITS - 1);

  state_e            state_q, state_d;
  logic [BITS-1:0]   n_q, n_d;
  logic [BITS-1:0]   np_q, np_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [BITS:0]     r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [BITS-1:0]   nprime_q, nprime_d;
  logic [BITS-1:0]   r2_q, r2_d;

  logic [BITS:0]     r_dbl;
  logic [CNT_W-2:0]  bit_idx;

  assign bit_idx = cnt_q[CNT_W-2:0];

  mod_double_step #(
    .W(BITS)
  ) u_dbl (
    .r_i (r_q),
    .n_i (n_q),
    .r2_o(r_dbl)
  );

  // Next-state, datapath updates and busy decode.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    np_d     = np_q;
    acc_d    = acc_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    nprime_d = nprime_q;
    r2_d     = r2_q;
    done_d   = (state_q == FIN);
    busy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!N[0] || (N == BITS'(1))) begin
            error_d  = 1'b1;
            nprime_d = '0;
            r2_d     = '0;
            state_d  = FIN;
          end else begin
            n_d     = N;
            np_d    = '0;
            acc_d   = '0;
            r_d     = (BITS + 1)'(1);
            cnt_d   = '0;
            error_d = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        busy = 1'b1;
        // Hensel lifting: set np bit k whenever acc bit k is still 0, keeping
        // acc == np*N mod 2^BITS; it ends all-ones, i.e. np*N == -1.
        if (cnt_q < CNT_NP_END) begin
          if (!acc_q[bit_idx]) begin
            np_d[bit_idx] = 1'b1;
            acc_d         = acc_q + (n_q << bit_idx);
          end
        end
        r_d   = r_dbl;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          nprime_d = np_d;
          r2_d     = r_dbl[BITS-1:0];
          state_d  = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything, including RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      np_q     <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      nprime_q <= '0;
      r2_q     <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      np_q     <= np_d;
      acc_q    <= acc_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
      nprime_q <= nprime_d;
      r2_q     <= r2_d;
    end
  end

  assign done    = done_q;
  assign error   = error_q;
  assign N_prime = nprime_q;
  assign R2      = r2_q;

endmodule

// File: tb/tb_montgomery_precompute.sv
// Self-checking bench for montgomery_precompute against an arithmetic model
// (Newton inversion for N_prime, 64-bit modular squaring for R2).
module tb_montgomery_precompute;
  import montgomery_precompute_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [BITS-1:0] N;
  logic            busy;
  logic            done;
  logic            error;
  logic [BITS-1:0] N_prime;
  logic [BITS-1:0] R2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  montgomery_precompute dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .N      (N),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .N_prime(N_prime),
    .R2     (R2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] n);
    return (n[0] == 1'b0) || (n == 32'd1);
  endfunction

  // Newton iteration x <- x*(2 - n*x) doubles correct low bits each pass.
  function automatic logic [31:0] ref_np(input logic [31:0] n);
    logic [31:0] x;
    x = n;
    for (int i = 0; i < 5; i++) x = x * (32'd2 - n * x);
    return -x;
  endfunction

  function automatic logic [31:0] ref_r2(input logic [31:0] n);
    longint unsigned m;
    m = 64'h1_0000_0000 % {32'd0, n};
    return 32'((m * m) % {32'd0, n});
  endfunction

  // One run: checks latency, busy span, results, single-cycle done and holding.
  task automatic run_one(input logic [31:0] n, input bit disturb);
    int          cyc, busy_cnt, done_cyc, hold;
    bit          eerr;
    logic [31:0] enp, er2;
    eerr = ref_err(n);
    enp  = eerr ? 32'd0 : ref_np(n);
    er2  = eerr ? 32'd0 : ref_r2(n);
    @(negedge clk);
    start = 1'b1;
    N     = n;
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (disturb && (cyc == 5 || cyc == 20 || cyc == 40)) begin
        start = 1'b1;
        N     = 32'd13;
      end else begin
        start = 1'b0;
        N     = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("latency", done_cyc, eerr ? 2 : 2 * BITS + 2);
    check("busy_cycles", busy_cnt, eerr ? 0 : 2 * BITS);
    check("error", error, eerr);
    check("n_prime", N_prime, enp);
    check("r2", R2, er2);
    hold = disturb ? 80 : 20;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("no_extra_done", done, 0);
      check("busy_idle", busy, 0);
      check("hold_np", N_prime, enp);
      check("hold_r2", R2, er2);
      check("hold_err", error, eerr);
    end
  endtask

  initial begin
    int cyc, ndone, nbusy;
    int done_at[$];
    logic [31:0] n;

    reset = 1'b1;
    start = 1'b0;
    N     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_np", N_prime, 0);
    check("rst_r2", R2, 0);
    reset = 1'b0;

    // Spec reference values through the model and DUT.
    run_one(32'd4292870399, 1'b0);
    check("case1_np", N_prime, 32'd3235971329);
    check("case1_r2", R2, 32'd1077740033);
    run_one(32'd13, 1'b0);
    check("case2_np", N_prime, 32'd991146299);
    check("case2_r2", R2, 32'd3);
    run_one(32'hFFFF_FFFF, 1'b0);
    check("allones_np", N_prime, 32'd1);
    check("allones_r2", R2, 32'd1);

    // Reset in the middle of a run: everything clears, no done.
    @(negedge clk);
    start = 1'b1;
    N     = 32'd4292870399;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_np", N_prime, 0);
    check("abort_r2", R2, 0);
    check("abort_err", error, 0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_one(32'd13, 1'b0);

    // Rejected moduli.
    run_one(32'd10, 1'b0);
    run_one(32'd1, 1'b0);

    // Starts during RUN are ignored.
    run_one(32'd4292870399, 1'b1);

    // Start held high: back-to-back runs every 66 cycles.
    @(negedge clk);
    start = 1'b1;
    N     = 32'd13;
    nbusy = 0;
    for (cyc = 1; cyc <= 3 * 66 + 10; cyc++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        done_at.push_back(cyc);
        check("b2b_np", N_prime, ref_np(32'd13));
        check("b2b_r2", R2, ref_r2(32'd13));
        check("b2b_err", error, 0);
      end
    end
    start = 1'b0;
    check("b2b_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check("b2b_first", done_at[0], 66);
      check("b2b_gap1", done_at[1] - done_at[0], 66);
      check("b2b_gap2", done_at[2] - done_at[1], 66);
    end
    check("b2b_busy", nbusy, 3 * 64 + 10);
    repeat (80) @(negedge clk);

    // Randomized moduli, a quarter of them even.
    for (int i = 0; i < 10; i++) begin
      n = $urandom;
      if (i % 4 == 0) n[0] = 1'b0;
      else            n[0] = 1'b1;
      run_one(n, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
